// File: rtl/swt16_pkg.sv
// Shared definitions for the swt16 program loader: FSM encoding, checksum width
// and small helpers used by the loader datapath.
package swt16_pkg;

  // Loader FSM states, in frame order.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN_HI  = 3'd1,
    ST_LEN_LO  = 3'd2,
    ST_DATA_HI = 3'd3,
    ST_DATA_LO = 3'd4,
    ST_CSUM    = 3'd5,
    ST_DONE    = 3'd6,
    ST_ERROR   = 3'd7
  } loader_state_e;

  localparam int CSUM_WIDTH = 8;

  // Modulo-256 checksum accumulation.
  function automatic logic [CSUM_WIDTH-1:0] csum_add(input logic [CSUM_WIDTH-1:0] sum,
                                                     input logic [7:0] data);
    return sum + data;
  endfunction

  // States in which the loader takes stream bytes.
  function automatic logic state_accepts_byte(input loader_state_e s);
    logic acc;
    case (s)
      ST_LEN_HI, ST_LEN_LO, ST_DATA_HI, ST_DATA_LO, ST_CSUM: acc = 1'b1;
      default:                                              acc = 1'b0;
    endcase
    return acc;
  endfunction

  // States whose bytes count toward the running checksum (everything but CSUM).
  function automatic logic state_sums_byte(input loader_state_e s);
    logic acc;
    case (s)
      ST_LEN_HI, ST_LEN_LO, ST_DATA_HI, ST_DATA_LO: acc = 1'b1;
      default:                                      acc = 1'b0;
    endcase
    return acc;
  endfunction

endpackage

// File: rtl/swt16_pmem_loader_byte_to_word.sv
// Assembles a 16-bit word from a high byte and a low byte and emits a
// one-cycle registered word-valid pulse when the low byte arrives.
module byte_to_word (
  input  logic        clock,
  input  logic        reset,
  input  logic        hi_load,
  input  logic        lo_load,
  input  logic [7:0]  data,
  output logic [15:0] word,
  output logic        word_valid
);

  logic [7:0]  hi_r;
  logic [15:0] word_r;
  logic        valid_r;

  // Hold the high byte until its low partner shows up.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hi_r <= 8'd0;
    end else if (hi_load) begin
      hi_r <= data;
    end else begin
      hi_r <= hi_r;
    end
  end

  // Register the completed word and pulse valid for exactly one cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      word_r  <= 16'd0;
      valid_r <= 1'b0;
    end else if (lo_load) begin
      word_r  <= {hi_r, data};
      valid_r <= 1'b1;
    end else begin
      word_r  <= word_r;
      valid_r <= 1'b0;
    end
  end

  assign word       = word_r;
  assign word_valid = valid_r;

endmodule

// File: rtl/swt16_pmem_loader.sv
// Boot-time program loader: parses a length/data/checksum byte frame, writes
// the words into pmem and releases the core only after a verified frame.
module swt16_pmem_loader
  import swt16_pkg::*;
#(
  parameter int PMEM_ADDR_WIDTH = 12,
  parameter int PMEM_WORD_WIDTH = 16,
  parameter int PMEM_NUM_WORDS  = 2048,
  parameter int PC_INCREMENT    = 2,
  parameter int BASE_ADDR       = 0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_start,
  input  logic                       in_byte_valid,
  input  logic [7:0]                 in_byte,
  output logic                       out_byte_ready,
  output logic                       out_pmem_write_en,
  output logic [PMEM_ADDR_WIDTH-1:0] out_pmem_addr,
  output logic [PMEM_WORD_WIDTH-1:0] out_pmem_word,
  output logic                       out_core_hold,
  output logic                       out_done,
  output logic                       out_error
);

  localparam logic [15:0] MAX_LEN = 16'(PMEM_NUM_WORDS);

  loader_state_e             state_r;
  loader_state_e             state_next_s;
  logic                      ready_r;
  logic                      hold_r;
  logic                      done_r;
  logic                      error_r;
  logic [7:0]                len_hi_r;
  logic [15:0]               len_r;
  logic [15:0]               idx_r;
  logic [CSUM_WIDTH-1:0]     sum_r;
  logic [PMEM_ADDR_WIDTH-1:0] addr_r;
  logic [15:0]               word_s;
  logic                      word_valid_s;
  logic                      transfer_s;
  logic [15:0]               len_s;
  logic                      last_word_s;
  logic                      entering_len_hi_s;
  logic [PMEM_ADDR_WIDTH-1:0] word_addr_s;

  // ready_r mirrors the current state, so a transfer is a plain valid & ready.
  assign transfer_s        = in_byte_valid & ready_r;
  assign len_s             = {len_hi_r, in_byte};
  assign last_word_s       = ((idx_r + 16'd1) == len_r);
  assign entering_len_hi_s = (state_next_s == ST_LEN_HI) && (state_r != ST_LEN_HI);
  assign word_addr_s       = PMEM_ADDR_WIDTH'(BASE_ADDR)
                           + PMEM_ADDR_WIDTH'(idx_r) * PMEM_ADDR_WIDTH'(PC_INCREMENT);

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode; in_start is only honoured outside an active session.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_start) state_next_s = ST_LEN_HI;
        else          state_next_s = ST_IDLE;
      end
      ST_LEN_HI: begin
        if (transfer_s) state_next_s = ST_LEN_LO;
        else            state_next_s = ST_LEN_HI;
      end
      ST_LEN_LO: begin
        if (!transfer_s)           state_next_s = ST_LEN_LO;
        else if (len_s > MAX_LEN)  state_next_s = ST_ERROR;
        else if (len_s == 16'd0)   state_next_s = ST_CSUM;
        else                       state_next_s = ST_DATA_HI;
      end
      ST_DATA_HI: begin
        if (transfer_s) state_next_s = ST_DATA_LO;
        else            state_next_s = ST_DATA_HI;
      end
      ST_DATA_LO: begin
        if (!transfer_s)      state_next_s = ST_DATA_LO;
        else if (last_word_s) state_next_s = ST_CSUM;
        else                  state_next_s = ST_DATA_HI;
      end
      ST_CSUM: begin
        if (!transfer_s)           state_next_s = ST_CSUM;
        else if (in_byte == sum_r) state_next_s = ST_DONE;
        else                       state_next_s = ST_ERROR;
      end
      ST_DONE, ST_ERROR: begin
        if (in_start) state_next_s = ST_LEN_HI;
        else          state_next_s = state_r;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Status outputs registered from the next state so they change with the state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ready_r <= 1'b0;
      hold_r  <= 1'b1;
      done_r  <= 1'b0;
      error_r <= 1'b0;
    end else begin
      ready_r <= state_accepts_byte(state_next_s);
      hold_r  <= (state_next_s != ST_DONE);
      done_r  <= (state_next_s == ST_DONE);
      error_r <= (state_next_s == ST_ERROR);
    end
  end

  // Running checksum: cleared when a session opens, summed over non-CSUM bytes.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sum_r <= '0;
    end else if (entering_len_hi_s) begin
      sum_r <= '0;
    end else if (transfer_s && state_sums_byte(state_r)) begin
      sum_r <= csum_add(sum_r, in_byte);
    end else begin
      sum_r <= sum_r;
    end
  end

  // Frame length capture.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      len_hi_r <= 8'd0;
      len_r    <= 16'd0;
    end else if (transfer_s && (state_r == ST_LEN_HI)) begin
      len_hi_r <= in_byte;
      len_r    <= len_r;
    end else if (transfer_s && (state_r == ST_LEN_LO)) begin
      len_hi_r <= len_hi_r;
      len_r    <= len_s;
    end else begin
      len_hi_r <= len_hi_r;
      len_r    <= len_r;
    end
  end

  // Word index and write address; the address lines up with the word-valid pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx_r  <= 16'd0;
      addr_r <= '0;
    end else if (entering_len_hi_s) begin
      idx_r  <= 16'd0;
      addr_r <= addr_r;
    end else if (transfer_s && (state_r == ST_DATA_LO)) begin
      idx_r  <= idx_r + 16'd1;
      addr_r <= word_addr_s;
    end else begin
      idx_r  <= idx_r;
      addr_r <= addr_r;
    end
  end

  byte_to_word u_byte_to_word (
    .clock      (clock),
    .reset      (reset),
    .hi_load    (transfer_s && (state_r == ST_DATA_HI)),
    .lo_load    (transfer_s && (state_r == ST_DATA_LO)),
    .data       (in_byte),
    .word       (word_s),
    .word_valid (word_valid_s)
  );

  assign out_byte_ready    = ready_r;
  assign out_pmem_write_en = word_valid_s;
  assign out_pmem_addr     = addr_r;
  assign out_pmem_word     = PMEM_WORD_WIDTH'(word_s);
  assign out_core_hold     = hold_r;
  assign out_done          = done_r;
  assign out_error         = error_r;

endmodule

// File: tb/tb_swt16_pmem_loader.sv
// Directed bench for swt16_pmem_loader with a frame-level reference model and
// a per-cycle output comparison, plus literal spot checks.
module tb_swt16_pmem_loader;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_start;
  logic        in_byte_valid;
  logic [7:0]  in_byte;
  logic        out_byte_ready;
  logic        out_pmem_write_en;
  logic [11:0] out_pmem_addr;
  logic [15:0] out_pmem_word;
  logic        out_core_hold;
  logic        out_done;
  logic        out_error;

  swt16_pmem_loader dut (
    .clock             (clock),
    .reset             (reset),
    .in_start          (in_start),
    .in_byte_valid     (in_byte_valid),
    .in_byte           (in_byte),
    .out_byte_ready    (out_byte_ready),
    .out_pmem_write_en (out_pmem_write_en),
    .out_pmem_addr     (out_pmem_addr),
    .out_pmem_word     (out_pmem_word),
    .out_core_hold     (out_core_hold),
    .out_done          (out_done),
    .out_error         (out_error)
  );

  always #5 clock = ~clock;

  int compared   = 0;
  int mismatched = 0;
  bit checking   = 1'b0;

  logic [15:0] mem [0:4095];
  int wcount = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level reference model: counts accepted bytes in the frame and
  // derives length, words, addresses and checksum from the byte position.
  bit          m_active, m_done, m_error, m_wen;
  logic [11:0] m_addr;
  logic [15:0] m_word;
  int          m_n, m_len;
  logic [7:0]  m_sum, m_hi;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_active = 1'b0; m_done = 1'b0; m_error = 1'b0; m_wen = 1'b0; m_n = 0;
    end else begin
      m_wen = 1'b0;
      if (!m_active) begin
        if (in_start) begin
          m_active = 1'b1; m_done = 1'b0; m_error = 1'b0; m_n = 0; m_sum = 8'd0;
        end
      end else if (in_byte_valid) begin
        if (m_n == 0) begin
          m_len = int'(in_byte) * 256;
          m_sum = m_sum + in_byte;
        end else if (m_n == 1) begin
          m_len = m_len + int'(in_byte);
          m_sum = m_sum + in_byte;
          if (m_len > 2048) begin
            m_active = 1'b0; m_error = 1'b1;
          end
        end else if (m_n < 2 + 2 * m_len) begin
          m_sum = m_sum + in_byte;
          if ((m_n % 2) == 0) begin
            m_hi = in_byte;
          end else begin
            m_wen  = 1'b1;
            m_word = {m_hi, in_byte};
            m_addr = 12'(((m_n - 3) / 2) * 2);
          end
        end else begin
          m_active = 1'b0;
          if (in_byte == m_sum) m_done = 1'b1;
          else                  m_error = 1'b1;
        end
        m_n++;
      end
    end
  end

  // Per-cycle comparison against the model, and a shadow pmem of observed writes.
  always @(negedge clock) begin
    if (checking) begin
      chk("ready", 32'(out_byte_ready), 32'(m_active));
      chk("done",  32'(out_done),       32'(m_done));
      chk("error", 32'(out_error),      32'(m_error));
      chk("hold",  32'(out_core_hold),  32'(!m_done));
      chk("wen",   32'(out_pmem_write_en), 32'(m_wen));
      if (m_wen) begin
        chk("waddr", 32'(out_pmem_addr), 32'(m_addr));
        chk("wdata", 32'(out_pmem_word), 32'(m_word));
      end
    end
    if (out_pmem_write_en === 1'b1) begin
      mem[out_pmem_addr] = out_pmem_word;
      wcount++;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    in_start = 1'b1;
    step();
    in_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int k;
    in_byte_valid = 1'b0;
    repeat (gap) step();
    in_byte_valid = 1'b1;
    in_byte = b;
    k = 0;
    while (!out_byte_ready && k < 20) begin
      step();
      k++;
    end
    if (!out_byte_ready) chk("accept_timeout", 32'd0, 32'd1);
    else step();
  endtask

  task automatic send_frame(input logic [7:0] f[$], input int maxgap);
    foreach (f[i]) send_byte(f[i], $urandom_range(maxgap, 0));
    in_byte_valid = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_ready"}, 32'(out_byte_ready),    32'd0);
    chk({tag, "_wen"},   32'(out_pmem_write_en), 32'd0);
    chk({tag, "_addr"},  32'(out_pmem_addr),     32'd0);
    chk({tag, "_word"},  32'(out_pmem_word),     32'd0);
    chk({tag, "_hold"},  32'(out_core_hold),     32'd1);
    chk({tag, "_done"},  32'(out_done),          32'd0);
    chk({tag, "_error"}, 32'(out_error),         32'd0);
  endtask

  initial begin
    logic [7:0] fr[$];
    logic [7:0] s;
    logic [15:0] w;
    int w0;

    reset = 1'b0; in_start = 1'b0; in_byte_valid = 1'b0; in_byte = 8'h00;
    repeat (3) step();
    check_reset_values("rst");
    reset = 1'b1;
    checking = 1'b1;
    step();

    // Three-word load, with a stray in_start mid-session that must be ignored.
    w0 = wcount;
    pulse_start();
    fr = '{8'h00, 8'h03, 8'h12, 8'h34};
    send_frame(fr, 0);
    in_start = 1'b1;
    send_byte(8'hAB, 0);
    in_start = 1'b0;
    fr = '{8'hCD, 8'h00, 8'h01, 8'hC2};
    send_frame(fr, 0);
    chk("t1_done",   32'(out_done), 32'd1);
    chk("t1_hold",   32'(out_core_hold), 32'd0);
    chk("t1_writes", 32'(wcount - w0), 32'd3);
    chk("t1_m0",     32'(mem[0]), 32'h1234);
    chk("t1_m2",     32'(mem[2]), 32'hABCD);
    chk("t1_m4",     32'(mem[4]), 32'h0001);
    step();

    // Restart from DONE, then a bad checksum.
    w0 = wcount;
    pulse_start();
    chk("t2_hold_re", 32'(out_core_hold), 32'd1);
    chk("t2_done_lo", 32'(out_done), 32'd0);
    fr = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'hC3};
    send_frame(fr, 0);
    chk("t2_error",  32'(out_error), 32'd1);
    chk("t2_hold",   32'(out_core_hold), 32'd1);
    chk("t2_writes", 32'(wcount - w0), 32'd3);
    step();

    // Oversize length; bytes offered afterwards are not consumed.
    w0 = wcount;
    pulse_start();
    fr = '{8'h08, 8'h01};
    send_frame(fr, 0);
    chk("t3_error", 32'(out_error), 32'd1);
    chk("t3_ready", 32'(out_byte_ready), 32'd0);
    in_byte_valid = 1'b1; in_byte = 8'h55;
    repeat (3) step();
    in_byte_valid = 1'b0;
    chk("t3_ready2", 32'(out_byte_ready), 32'd0);
    chk("t3_writes", 32'(wcount - w0), 32'd0);

    // Empty frame with random valid gaps.
    w0 = wcount;
    pulse_start();
    fr = '{8'h00, 8'h00, 8'h00};
    send_frame(fr, 3);
    chk("t4_done",   32'(out_done), 32'd1);
    chk("t4_writes", 32'(wcount - w0), 32'd0);
    step();

    // Reset between the high and low byte of the second word.
    w0 = wcount;
    pulse_start();
    fr = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33};
    send_frame(fr, 0);
    reset = 1'b0;
    #2;
    check_reset_values("t5_rst");
    step();
    reset = 1'b1;
    step();
    chk("t5_writes", 32'(wcount - w0), 32'd1);
    chk("t5_m0",     32'(mem[0]), 32'h1122);
    pulse_start();
    fr = '{8'h00, 8'h02, 8'hCA, 8'hFE, 8'h12, 8'h34, 8'h10};
    send_frame(fr, 1);
    chk("t5_done", 32'(out_done), 32'd1);
    chk("t5_m0b",  32'(mem[0]), 32'hCAFE);
    chk("t5_m2b",  32'(mem[2]), 32'h1234);
    step();

    // Reload from DONE with a one-word frame.
    pulse_start();
    chk("t6_hold_re", 32'(out_core_hold), 32'd1);
    chk("t6_done_lo", 32'(out_done), 32'd0);
    fr = '{8'h00, 8'h01, 8'hBE, 8'hEF, 8'hAE};
    send_frame(fr, 0);
    chk("t6_done", 32'(out_done), 32'd1);
    chk("t6_m0",   32'(mem[0]), 32'hBEEF);
    step();

    // Largest legal frame fills pmem up to the last word address.
    w0 = wcount;
    fr = '{8'h08, 8'h00};
    s = 8'h08;
    for (int i = 0; i < 2048; i++) begin
      w = 16'(i * 7 + 3) ^ 16'hA5C3;
      fr.push_back(w[15:8]);
      fr.push_back(w[7:0]);
      s = s + w[15:8] + w[7:0];
    end
    fr.push_back(s);
    pulse_start();
    send_frame(fr, 0);
    chk("t7_done",   32'(out_done), 32'd1);
    chk("t7_writes", 32'(wcount - w0), 32'd2048);
    w = 16'(2047 * 7 + 3) ^ 16'hA5C3;
    chk("t7_last",   32'(mem[12'hFFE]), 32'(w));
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
